sel_arb_4: RTL and testbench
============================

# sel_arb_4

Round-robin arbiter that shares one 4-to-1 selector between four requesters. Samples four request lines, grants one requester at a time for a bounded burst, and drives the selector's 2-bit select plus a one-hot grant vector. Sits directly in front of the 4:1 selector; its SEL output connects straight to the selector's SEL input.

## Interface
- BURST_LEN, 4: maximum consecutive grant cycles per owner; legal range 1..16.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- REQ  input  4  request lines; REQ[i] high means requester i wants the selector.
- LOCK  input  1  burst-limit override. Present only with SEL_ARB_LOCK_EN.
- GNT  output  4  one-hot grant, registered; all-zero when idle.
- SEL  output  2  selector select, registered; equals the index of the set GNT bit.
- VALID  output  1  registered; high whenever GNT is non-zero.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: one owner holds GNT.
- Priority pointer LAST (2 bits) holds the last granted index. The search order is LAST+1, LAST+2, LAST+3, LAST, modulo 4, so the current owner is checked last.
- IDLE:
  - Any REQ high: pick the first high bit in search order, set GNT/SEL/VALID, clear the burst counter CNT, set LAST to the winner, go to BUSY.
  - All REQ low: stay in IDLE with outputs zero.
- BUSY, owner o. Release condition: REQ[o] low, or CNT == BURST_LEN-1.
  - Release and another REQ high: grant the next requester in search order on the same edge. Back-to-back, no idle cycle; CNT cleared; LAST updated.
  - Release and only REQ[o] high (burst expired): o is re-granted for a fresh burst with CNT cleared.
  - Release and no REQ high: go to IDLE; GNT, SEL and VALID clear.
  - No release: CNT increments; outputs hold.
- A requester dropping REQ while not granted loses its pending request. There is no request latching.
- SEL holds its last value while idle is not allowed: SEL returns to 0 in IDLE.
- CNT width is 4 bits. CNT never exceeds BURST_LEN-1, so it cannot wrap.

## Timing
- Reset values: GNT=0000, SEL=00, VALID=0, state IDLE, LAST=3 (requester 0 has first priority), CNT=0.
- RST asserts asynchronously mid-burst: outputs clear immediately. The first grant follows on the first rising edge after RST deasserts with REQ high.
- Request-to-grant latency: 1 cycle. REQ sampled at edge t gives GNT valid after edge t.
- Release latency: the owner keeps GNT for the cycle in which it deasserts REQ. GNT moves or clears at the next edge.
- Maximum continuous ownership: BURST_LEN cycles. With BURST_LEN=1, grants rotate every cycle when all requesters are active.
- Simultaneous requests resolve the same cycle, strictly by round-robin order. There is no fixed priority beyond reset.

## Configuration
- SEL_ARB_LOCK_EN defined:
  - The LOCK port exists.
  - While LOCK is high in BUSY, the CNT limit is ignored. The owner keeps the grant until REQ[o] drops and CNT saturates at BURST_LEN-1.
  - LOCK is ignored in IDLE.
- SEL_ARB_LOCK_EN undefined: the LOCK port is absent, and every grant is bounded by BURST_LEN.

## Structure
- Package sel_arb_pkg:
  - NREQ=4 and SEL_W=2.
  - State type with IDLE and BUSY.
  - CNT_W=4.
- Sub-module sel_arb_rr_pick:
  - Combinational. Inputs REQ[3:0] and LAST[1:0]; outputs winner index [1:0] and FOUND.
  - The top level instantiates it once and contains the FSM, CNT and output registers.

## Test plan
- Reset, then REQ=0001 held, BURST_LEN=4:
  - GNT=0001, SEL=00, VALID=1 one cycle after the REQ edge.
  - Re-granted after each 4-cycle burst; GNT stays high continuously.
- REQ=1111 from IDLE after reset, BURST_LEN=2: grants cycle 0,1,2,3,0 with 2 cycles each and no VALID gap.
- Owner 1 drops REQ after 1 cycle with REQ[3] pending:
  - GNT=0010 for one more cycle, then GNT=1000, SEL=11.
  - All REQ low afterwards: GNT=0000, VALID=0, SEL=00 next cycle.
- RST pulsed mid-burst while GNT=0100:
  - Outputs clear asynchronously.
  - After release with REQ=1111, the first grant goes to requester 0.
- With SEL_ARB_LOCK_EN, BURST_LEN=2, REQ=0011, LOCK high for 6 cycles:
  - Requester 0 holds GNT for 6 cycles.
  - LOCK low: GNT moves to 0010 within at most 2 cycles.
- BURST_LEN=1, REQ=1010: GNT alternates 0010, 1000 every cycle.

Source files
------------

// File: rtl/sel_arb_pkg.sv
// Shared constants, the arbiter state type and a small decode helper for the
// sel_arb_4 round-robin selector arbiter.
//   NREQ  : number of requesters sharing the selector
//   SEL_W : width of the selector select / requester index
//   CNT_W : width of the burst counter
package sel_arb_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

   // Index to one-hot grant vector.
   function automatic logic [NREQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/sel_arb_rr_pick.sv
// Combinational round-robin picker. Searches req_i starting just after
// last_i and wrapping, so the index in last_i is considered last.
//   req_i    : request lines
//   last_i   : index of the most recently granted requester
//   winner_o : first requesting index in search order (0 when none)
//   found_o  : high when any request is present
module sel_arb_rr_pick
   import sel_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   input  logic [SEL_W-1:0] last_i,
   output logic [SEL_W-1:0] winner_o,
   output logic             found_o
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      winner_o = '0;
      found_o  = 1'b0;
      cand     = '0;
      // Walk from farthest to nearest so the nearest hit is assigned last and wins.
      for (int k = NREQ; k >= 1; k--) begin
         cand = last_i + SEL_W'(k);
         if (req_i[cand]) begin
            winner_o = cand;
            found_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sel_arb_4.sv
// Round-robin arbiter sharing one 4:1 selector among four requesters. Each
// owner holds the grant for at most BURST_LEN cycles, then the grant moves to
// the next requester in round-robin order with no idle cycle in between.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   lock_i  : burst-limit override (only with SEL_ARB_LOCK_EN defined)
//   req_i   : request lines, one per requester
//   gnt_o   : registered one-hot grant, zero when idle
//   sel_o   : registered selector select, index of the granted requester
//   valid_o : registered, high whenever gnt_o is non-zero
// Build option: SEL_ARB_LOCK_EN adds lock_i; while it is high in BUSY the
// owner keeps the grant until it drops its request.
module sel_arb_4
   import sel_arb_pkg::*;
#(
   parameter int unsigned BURST_LEN = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
`ifdef SEL_ARB_LOCK_EN
   input  logic             lock_i,
`endif
   input  logic [NREQ-1:0]  req_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             valid_o
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(BURST_LEN - 1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              valid_q, valid_d;

   logic [SEL_W-1:0]  winner;
   logic              found;
   logic              lock_act;
   logic              at_limit;
   logic              release_own;

   sel_arb_rr_pick u_pick (
      .req_i    (req_i),
      .last_i   (last_q),
      .winner_o (winner),
      .found_o  (found)
   );

`ifdef SEL_ARB_LOCK_EN
   assign lock_act = lock_i;
`else
   assign lock_act = 1'b0;
`endif

   assign at_limit = (cnt_q == CntMax);
   // In BUSY sel_q is the owner index.
   assign release_own = !req_i[sel_q] || (at_limit && !lock_act);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StBusy;
               last_d  = winner;
               cnt_d   = '0;
               gnt_d   = idx2onehot(winner);
               sel_d   = winner;
               valid_d = 1'b1;
            end
         end
         StBusy: begin
            if (release_own) begin
               if (found) begin
                  // Owner is searched last, so it is re-granted only when alone.
                  last_d  = winner;
                  cnt_d   = '0;
                  gnt_d   = idx2onehot(winner);
                  sel_d   = winner;
                  valid_d = 1'b1;
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  gnt_d   = '0;
                  sel_d   = '0;
                  valid_d = 1'b0;
               end
            end else if (!at_limit) begin
               // Saturates under lock; without lock the limit always releases.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            gnt_d   = '0;
            sel_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         last_q  <= SEL_W'(NREQ - 1);
         cnt_q   <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign sel_o   = sel_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_sel_arb_4.sv
// Bench for sel_arb_4: three instances (BURST_LEN 4, 2, 1) share clock, reset,
// request and lock. A behavioural model plus hand-written expectations feed a
// scoreboard queue that is drained after every rising edge.
module tb_sel_arb_4;

   logic       clk;
   logic       rst;
   logic       lock_r;
   logic [3:0] req_r;

   logic [3:0] g4, g2, g1;
   logic [1:0] s4, s2, s1;
   logic       v4, v2, v1;

   int n_total = 0;
   int n_bad   = 0;

   sel_arb_4 #(.BURST_LEN(4)) u_bl4 (
      .clk_i   (clk),
      .rst_i   (rst),
`ifdef SEL_ARB_LOCK_EN
      .lock_i  (lock_r),
`endif
      .req_i   (req_r),
      .gnt_o   (g4),
      .sel_o   (s4),
      .valid_o (v4)
   );

   sel_arb_4 #(.BURST_LEN(2)) u_bl2 (
      .clk_i   (clk),
      .rst_i   (rst),
`ifdef SEL_ARB_LOCK_EN
      .lock_i  (lock_r),
`endif
      .req_i   (req_r),
      .gnt_o   (g2),
      .sel_o   (s2),
      .valid_o (v2)
   );

   sel_arb_4 #(.BURST_LEN(1)) u_bl1 (
      .clk_i   (clk),
      .rst_i   (rst),
`ifdef SEL_ARB_LOCK_EN
      .lock_i  (lock_r),
`endif
      .req_i   (req_r),
      .gnt_o   (g1),
      .sel_o   (s1),
      .valid_o (v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: parallel queues of tag, instance index and {valid,sel,gnt}.
   string      tag_q[$];
   int         dut_q[$];
   logic [6:0] exp_q[$];

   // Reference model state per instance.
   int m_bl[3] = '{4, 2, 1};
   bit m_busy[3];
   int m_own[3];
   int m_last[3];
   int m_cnt[3];

   task automatic check_eq(input string tag, input logic [6:0] act, input logic [6:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act={v,sel,gnt}=%b exp=%b at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] get_out(input int k);
      case (k)
         0:       return {v4, s4, g4};
         1:       return {v2, s2, g2};
         default: return {v1, s1, g1};
      endcase
   endfunction

   function automatic logic [6:0] enc(input int idx);
      logic [3:0] g;
      logic [1:0] s;
      s = idx[1:0];
      g = 4'b0001 << s;
      return {1'b1, s, g};
   endfunction

   task automatic push(input string tag, input int k, input logic [6:0] e);
      tag_q.push_back(tag);
      dut_q.push_back(k);
      exp_q.push_back(e);
   endtask

   task automatic drain();
      while (tag_q.size() > 0) begin
         string      t;
         int         k;
         logic [6:0] e;
         t = tag_q.pop_front();
         k = dut_q.pop_front();
         e = exp_q.pop_front();
         check_eq($sformatf("%s[bl%0d]", t, m_bl[k]), get_out(k), e);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_busy[k] = 1'b0;
         m_own[k]  = 0;
         m_last[k] = 3;
         m_cnt[k]  = 0;
      end
   endtask

   task automatic model_step(input int k, input logic [3:0] req, input logic lock);
      bit rel;
      bit hit;
      int w;
      rel = !m_busy[k] || !req[m_own[k]] || ((m_cnt[k] == m_bl[k] - 1) && !lock);
      if (!rel) begin
         if (m_cnt[k] < m_bl[k] - 1) m_cnt[k]++;
      end else begin
         hit = 1'b0;
         w   = 0;
         for (int i = 1; i <= 4; i++) begin
            if (!hit && req[(m_last[k] + i) % 4]) begin
               hit = 1'b1;
               w   = (m_last[k] + i) % 4;
            end
         end
         m_busy[k] = hit;
         m_cnt[k]  = 0;
         if (hit) begin
            m_own[k]  = w;
            m_last[k] = w;
         end
      end
   endtask

   // Called at a falling edge: drive, predict, clock, compare.
   task automatic step(input logic [3:0] req, input logic lock);
      req_r  = req;
      lock_r = lock;
      for (int k = 0; k < 3; k++) begin
         model_step(k, req, lock);
         push("model", k, m_busy[k] ? enc(m_own[k]) : 7'd0);
      end
      @(posedge clk);
      #1;
      drain();
      @(negedge clk);
   endtask

   // Async reset pulse starting between edges; outputs must clear before any edge.
   task automatic reset_pulse(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 3; k++) push(tag, k, 7'd0);
      drain();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      req_r  = 4'b0000;
      lock_r = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) push("reset_state", k, 7'd0);
      drain();
      rst = 1'b0;

      // Single requester held: continuous grant across burst boundaries.
      for (int i = 0; i < 10; i++) begin
         push("hold_req0", 0, enc(0));
         step(4'b0001, 1'b0);
      end

      // All requesting from reset: BURST_LEN=2 rotates 0,1,2,3,0 two cycles each.
      reset_pulse("rst_before_rr");
      for (int i = 0; i < 9; i++) begin
         push("rr_all", 1, enc((i / 2) % 4));
         step(4'b1111, 1'b0);
      end

      // Owner 1 drops after one cycle with requester 3 pending, then all idle.
      step(4'b0000, 1'b0);
      push("own1_grant", 0, enc(1));
      step(4'b0010, 1'b0);
      push("own1_keep", 0, enc(1));
      step(4'b1010, 1'b0);
      push("own1_to3", 0, enc(3));
      step(4'b1000, 1'b0);
      push("to_idle", 0, 7'd0);
      step(4'b0000, 1'b0);

      // Reset asserted mid-burst while requester 2 owns; first grant goes to 0.
      push("own2", 0, enc(2));
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      reset_pulse("rst_mid_burst");
      for (int k = 0; k < 3; k++) push("first_after_rst", k, enc(0));
      step(4'b1111, 1'b0);

      // BURST_LEN=1 alternates between two requesters every cycle.
      for (int i = 0; i < 6; i++) begin
         push("bl1_alt", 2, enc((i % 2 == 0) ? 1 : 3));
         step(4'b1010, 1'b0);
      end

`ifdef SEL_ARB_LOCK_EN
      // Lock holds requester 0 past the limit; grant moves once lock drops.
      reset_pulse("rst_before_lock");
      for (int i = 0; i < 6; i++) begin
         push("lock_hold", 1, enc(0));
         step(4'b0011, 1'b1);
      end
      push("lock_release", 1, enc(1));
      step(4'b0011, 1'b0);
`endif

      // Random traffic checked against the model.
      for (int i = 0; i < 300; i++) begin
         logic [3:0] r;
         logic       l;
         r = 4'($urandom_range(0, 15));
         l = 1'b0;
`ifdef SEL_ARB_LOCK_EN
         l = ($urandom_range(0, 3) == 0);
`endif
         step(r, l);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
